// File: rtl/spi_pkg.sv
// Shared definitions for the parametrised SPI slave front-end.
//   spi_state_e : receive/transmit FSM states
//   CMD_*       : 2-bit command codes carried in the frame MSBs
//   frame_w()   : frame width for a given payload width (command + payload)
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHK_CMD,
    ST_WRITE,
    ST_READ_ADD,
    ST_READ_DATA,
    ST_TX_WAIT,
    ST_TX_SHIFT,
    ST_HOLD
  } spi_state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  function automatic int frame_w(input int data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/spi_slave_param_if.sv
// Bus bundle between an SPI master / RAM controller and the SPI slave.
//   SS_n, MOSI          : serial side, driven by the master
//   MISO                : serial read data back to the master
//   rx_data, rx_valid   : received frame {cmd, payload} and its one-cycle strobe
//   tx_data, tx_valid   : read data offered by the RAM controller
//   busy, frame_err     : slave activity flag and abort/timeout pulse
interface spi_slave_param_if
  import spi_pkg::*;
#(
  parameter int DATA_W = 8
);
  localparam int FRAME_W = frame_w(DATA_W);

  logic               SS_n;
  logic               MOSI;
  logic               MISO;
  logic [FRAME_W-1:0] rx_data;
  logic               rx_valid;
  logic [DATA_W-1:0]  tx_data;
  logic               tx_valid;
  logic               busy;
  logic               frame_err;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid, busy, frame_err
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid, busy, frame_err
  );

endinterface

// File: rtl/spi_tx_shifter.sv
// MSB-first parallel-in/serial-out shifter for SPI read data.
//   clk, rst : clock and asynchronous active-high reset
//   load_i   : capture data_i; its MSB appears on bit_o from this edge
//   data_i   : parallel word to send
//   shift_i  : advance one bit (zero fill, so the output settles to 0)
//   clear_i  : drop any word in flight, output 0 (takes priority)
//   bit_o    : current serial bit
//   done_o   : the last bit is on bit_o; the next shift empties the shifter
module spi_tx_shifter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              shift_i,
  input  logic              clear_i,
  output logic              bit_o,
  output logic              done_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (load_i) begin
      shift_d = data_i;
      cnt_d   = CNT_W'(DATA_W - 1);
    end else if (shift_i) begin
      shift_d = shift_q << 1;
      if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bit_o  = shift_q[DATA_W-1];
  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave: deserialises {cmd, payload} frames from MOSI and
// serialises RAM read data onto MISO. clk doubles as the SPI bit clock.
//   clk, rst : system/bit clock, asynchronous active-high reset
//   bus      : slave modport of spi_slave_param_if (serial lines, rx/tx
//              handshakes, busy, frame_err)
// Read addresses and read data share the command MSB; which one a frame is
// depends on whether a read address has already been received.
module spi_slave_param
  import spi_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int TX_TIMEOUT = 16
) (
  input logic                clk,
  input logic                rst,
  spi_slave_param_if.slave   bus
);

  localparam int FRAME_W = frame_w(DATA_W);
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int TO_W    = (TX_TIMEOUT > 0) ? $clog2(TX_TIMEOUT + 1) : 1;

  spi_state_e         state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-2:0] rx_shift_q, rx_shift_d;   // all bits but the last
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               frame_err_q, frame_err_d;
  logic               rd_addr_seen_q, rd_addr_seen_d;
  logic [TO_W-1:0]    wait_cnt_q, wait_cnt_d;

  logic tx_load, tx_shift, tx_clear, tx_done, tx_bit;
  logic last_bit;

  assign last_bit = (bit_cnt_q == CNT_W'(FRAME_W - 1));

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    rx_shift_d     = rx_shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    frame_err_d    = 1'b0;
    rd_addr_seen_d = rd_addr_seen_q;
    wait_cnt_d     = wait_cnt_q;
    tx_load        = 1'b0;
    tx_shift       = 1'b0;
    tx_clear       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!bus.SS_n) state_d = ST_CHK_CMD;
      end

      ST_CHK_CMD: begin
        if (bus.SS_n) begin
          state_d = ST_IDLE;
        end else begin
          rx_shift_d = {{(FRAME_W-2){1'b0}}, bus.MOSI};
          bit_cnt_d  = CNT_W'(1);
          if (bus.MOSI == CMD_WR_ADDR[1]) state_d = ST_WRITE;
          else if (rd_addr_seen_q)        state_d = ST_READ_DATA;
          else                            state_d = ST_READ_ADD;
        end
      end

      ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
        // The edge sampling the final bit completes the frame; SS_n only
        // chooses where to go next. Earlier SS_n-high edges are aborts.
        if (last_bit) begin
          rx_data_d  = {rx_shift_q, bus.MOSI};
          rx_valid_d = 1'b1;
          if (state_q == ST_READ_DATA) begin
            rd_addr_seen_d = 1'b0;
            wait_cnt_d     = '0;
            state_d        = ST_TX_WAIT;
          end else begin
            if (state_q == ST_READ_ADD) rd_addr_seen_d = 1'b1;
            state_d = bus.SS_n ? ST_IDLE : ST_CHK_CMD;
          end
        end else if (bus.SS_n) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          rx_shift_d = {rx_shift_q[FRAME_W-3:0], bus.MOSI};
          bit_cnt_d  = bit_cnt_q + CNT_W'(1);
        end
      end

      ST_TX_WAIT: begin
        if (bus.SS_n) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (bus.tx_valid) begin
          tx_load = 1'b1;
          state_d = ST_TX_SHIFT;
        end else if (TX_TIMEOUT != 0) begin
          if (wait_cnt_q == TO_W'(TX_TIMEOUT - 1)) begin
            frame_err_d = 1'b1;
            state_d     = ST_HOLD;
          end else begin
            wait_cnt_d = wait_cnt_q + TO_W'(1);
          end
        end
      end

      ST_TX_SHIFT: begin
        tx_shift = 1'b1;
        if (tx_done) begin
          state_d = bus.SS_n ? ST_IDLE : ST_CHK_CMD;
        end else if (bus.SS_n) begin
          tx_clear    = 1'b1;
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      ST_HOLD: begin
        if (bus.SS_n) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      bit_cnt_q      <= '0;
      rx_shift_q     <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      frame_err_q    <= 1'b0;
      rd_addr_seen_q <= 1'b0;
      wait_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      rx_shift_q     <= rx_shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      frame_err_q    <= frame_err_d;
      rd_addr_seen_q <= rd_addr_seen_d;
      wait_cnt_q     <= wait_cnt_d;
    end
  end

  spi_tx_shifter #(
    .DATA_W (DATA_W)
  ) u_tx_shifter (
    .clk     (clk),
    .rst     (rst),
    .load_i  (tx_load),
    .data_i  (bus.tx_data),
    .shift_i (tx_shift),
    .clear_i (tx_clear),
    .bit_o   (tx_bit),
    .done_o  (tx_done)
  );

  assign bus.MISO      = tx_bit;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_slave_param.sv
// Self-checking bench for spi_slave_param (DATA_W=8). The reference model is
// the command-routing rule (write / read address / read data) plus the frame
// and MISO timing expressed as cycle offsets from the start of each frame.
module tb_spi_slave_param;
  import spi_pkg::*;

  localparam int DATA_W     = 8;
  localparam int FRAME_W    = DATA_W + 2;
  localparam int TX_TIMEOUT = 16;

  logic clk;
  logic rst;

  spi_slave_param_if #(.DATA_W(DATA_W)) bus ();

  spi_slave_param #(
    .DATA_W     (DATA_W),
    .TX_TIMEOUT (TX_TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model state: has a read address been accepted since the last read data?
  bit model_seen = 1'b0;
  logic [FRAME_W-1:0] model_last_rx = '0;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Returns 1 when the frame is a read-data frame, updating the model flag.
  function automatic bit model_route(input logic [1:0] cmd);
    if (cmd[1] == 1'b0) return 1'b0;
    if (model_seen) begin
      model_seen = 1'b0;
      return 1'b1;
    end
    model_seen = 1'b1;
    return 1'b0;
  endfunction

  // Drives one frame starting with the FSM ready to sample the MSB.
  task automatic drive_frame(input logic [FRAME_W-1:0] word, output bit is_rd);
    logic [3:0] obs, exp;
    is_rd = model_route(word[FRAME_W-1 -: 2]);
    for (int i = FRAME_W - 1; i >= 0; i--) begin
      bus.MOSI     = word[i];
      bus.tx_valid = 1'($urandom_range(0, 1));
      bus.tx_data  = 8'($urandom);
      tick();
      obs = {bus.busy, bus.MISO, bus.frame_err, bus.rx_valid};
      exp = {1'b1, 1'b0, 1'b0, (i == 0)};
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL frame_bit%0d word=%h {busy,miso,err,rxv} got=%b exp=%b", i, word, obs, exp);
      end
    end
    n_vec++;
    if (bus.rx_data !== word) begin
      n_err++;
      $display("FAIL rx_data got=%h exp=%h", bus.rx_data, word);
    end
    model_last_rx = word;
    bus.tx_valid = 1'b0;
  endtask

  // In TX_WAIT: idle wait_n edges, then present d and check the MISO stream.
  task automatic tx_phase(input int wait_n, input logic [DATA_W-1:0] d);
    logic [2:0] obs;
    for (int w = 0; w < wait_n; w++) begin
      bus.tx_valid = 1'b0;
      tick();
      obs = {bus.MISO, bus.frame_err, bus.busy};
      n_vec++;
      if (obs !== 3'b001) begin
        n_err++;
        $display("FAIL tx_wait%0d {miso,err,busy} got=%b exp=001", w, obs);
      end
    end
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    tick();
    for (int b = DATA_W - 1; b >= -1; b--) begin
      logic exp_bit;
      exp_bit = (b >= 0) ? d[b] : 1'b0;
      n_vec++;
      if (bus.MISO !== exp_bit || bus.frame_err !== 1'b0) begin
        n_err++;
        $display("FAIL miso_bit%0d data=%h got=%b err=%b exp=%b", b, d, bus.MISO, bus.frame_err, exp_bit);
      end
      if (b >= 0) begin
        bus.tx_valid = 1'($urandom_range(0, 1));
        bus.tx_data  = 8'($urandom);
        tick();
      end
    end
    bus.tx_valid = 1'b0;
  endtask

  task automatic start_frame();
    bus.SS_n = 1'b0;
    tick();
  endtask

  // FSM sits in CHK_CMD; raising SS_n must return to IDLE quietly.
  task automatic end_frame(input string tag);
    logic [3:0] obs;
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    tick();
    obs = {bus.busy, bus.frame_err, bus.rx_valid, bus.MISO};
    n_vec++;
    if (obs !== 4'b0000) begin
      n_err++;
      $display("FAIL %s end {busy,err,rxv,miso} got=%b exp=0000", tag, obs);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.SS_n = 1'b1; bus.MOSI = 1'b0; bus.tx_valid = 1'b0; bus.tx_data = '0;
    #2;
    n_vec++;
    if ({bus.MISO, bus.rx_valid, bus.busy, bus.frame_err} !== 4'b0 || bus.rx_data !== '0) begin
      n_err++;
      $display("FAIL reset_state got miso=%b rxv=%b busy=%b err=%b rx=%h exp all 0",
               bus.MISO, bus.rx_valid, bus.busy, bus.frame_err, bus.rx_data);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    n_vec++;
    if ({bus.MISO, bus.rx_valid, bus.busy, bus.frame_err} !== 4'b0) begin
      n_err++;
      $display("FAIL post_reset_idle got %b exp 0000", {bus.MISO, bus.rx_valid, bus.busy, bus.frame_err});
    end
    model_seen = 1'b0;
  endtask

  task automatic test_write_addr();
    bit rd;
    start_frame();
    n_vec++;
    if (bus.busy !== 1'b1 || bus.rx_valid !== 1'b0) begin
      n_err++;
      $display("FAIL chk_cmd_entry busy=%b rxv=%b exp busy=1 rxv=0", bus.busy, bus.rx_valid);
    end
    drive_frame({CMD_WR_ADDR, 8'hA5}, rd);
    end_frame("write_addr");
  endtask

  task automatic test_back_to_back();
    bit rd;
    start_frame();
    drive_frame({CMD_WR_ADDR, 8'hA5}, rd);
    drive_frame({CMD_WR_DATA, 8'h3C}, rd);
    end_frame("back_to_back");
  endtask

  task automatic test_read_seq();
    bit rd;
    start_frame();
    drive_frame({CMD_RD_ADDR, 8'h12}, rd);
    drive_frame({CMD_RD_DATA, 8'h00}, rd);
    n_vec++;
    if (rd !== 1'b1) begin
      n_err++;
      $display("FAIL read_seq_route model got=%b exp=1", rd);
    end
    tx_phase(2, 8'h96);
    end_frame("read_seq");
  endtask

  task automatic test_abort();
    bit rd;
    logic [FRAME_W-1:0] w;
    logic [3:0] obs;
    start_frame();
    drive_frame({CMD_RD_ADDR, 8'($urandom)}, rd);
    w = FRAME_W'($urandom);
    for (int i = FRAME_W - 1; i >= FRAME_W - 5; i--) begin
      bus.MOSI = w[i];
      tick();
      obs = {bus.busy, bus.frame_err, bus.rx_valid, bus.MISO};
      n_vec++;
      if (obs !== 4'b1000) begin
        n_err++;
        $display("FAIL abort_bit%0d {busy,err,rxv,miso} got=%b exp=1000", i, obs);
      end
    end
    bus.SS_n = 1'b1;
    tick();
    obs = {bus.busy, bus.frame_err, bus.rx_valid, bus.MISO};
    n_vec++;
    if (obs !== 4'b0100 || bus.rx_data !== model_last_rx) begin
      n_err++;
      $display("FAIL abort_pulse {busy,err,rxv,miso} got=%b exp=0100 rx=%h exp=%h",
               obs, bus.rx_data, model_last_rx);
    end
    tick();
    n_vec++;
    if (bus.frame_err !== 1'b0) begin
      n_err++;
      $display("FAIL abort_pulse_width err got=%b exp=0", bus.frame_err);
    end
    // The read address must survive the abort: the next MSB-1 frame is read data.
    start_frame();
    drive_frame({CMD_RD_DATA, 8'($urandom)}, rd);
    tx_phase($urandom_range(0, 4), 8'($urandom));
    end_frame("abort_followup");
  endtask

  task automatic test_timeout();
    bit rd;
    logic [2:0] obs, exp;
    start_frame();
    drive_frame({CMD_RD_ADDR, 8'($urandom)}, rd);
    drive_frame({CMD_RD_DATA, 8'($urandom)}, rd);
    for (int j = 1; j <= TX_TIMEOUT + 4; j++) begin
      // Once in HOLD, tx_valid must not restart the transmitter.
      bus.tx_valid = (j > TX_TIMEOUT);
      bus.tx_data  = 8'hFF;
      tick();
      obs = {bus.frame_err, bus.MISO, bus.busy};
      exp = {(j == TX_TIMEOUT), 1'b0, 1'b1};
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL timeout_cyc%0d {err,miso,busy} got=%b exp=%b", j, obs, exp);
      end
    end
    bus.tx_valid = 1'b0;
    end_frame("timeout");
  endtask

  task automatic test_reset_mid_tx();
    bit rd;
    logic [DATA_W-1:0] d;
    start_frame();
    drive_frame({CMD_RD_ADDR, 8'($urandom)}, rd);
    drive_frame({CMD_RD_DATA, 8'($urandom)}, rd);
    d = {4'hF, 4'($urandom)};
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    tick();
    bus.tx_valid = 1'b0;
    tick(); tick();
    n_vec++;
    if (bus.MISO !== d[DATA_W-3]) begin
      n_err++;
      $display("FAIL pre_reset_miso got=%b exp=%b", bus.MISO, d[DATA_W-3]);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if ({bus.MISO, bus.rx_valid, bus.busy, bus.frame_err} !== 4'b0 || bus.rx_data !== '0) begin
      n_err++;
      $display("FAIL mid_tx_reset got miso=%b rxv=%b busy=%b err=%b rx=%h exp all 0",
               bus.MISO, bus.rx_valid, bus.busy, bus.frame_err, bus.rx_data);
    end
    tick();
    n_vec++;
    if (bus.frame_err !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_no_err err=%b busy=%b exp 0 0", bus.frame_err, bus.busy);
    end
    rst = 1'b0;
    bus.SS_n = 1'b1;
    model_seen = 1'b0;
    tick();
    // Routed to READ_ADD, so raising SS_n afterwards is a clean end, not an abort.
    start_frame();
    drive_frame({CMD_RD_ADDR, 8'($urandom)}, rd);
    end_frame("post_reset_read_addr");
  endtask

  task automatic test_random();
    bit rd;
    for (int burst = 0; burst < 12; burst++) begin
      int nfr;
      start_frame();
      nfr = $urandom_range(1, 3);
      for (int f = 0; f < nfr; f++) begin
        drive_frame({2'($urandom), 8'($urandom)}, rd);
        if (rd) tx_phase($urandom_range(0, 6), 8'($urandom));
      end
      end_frame("random");
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench watchdog");
  end

  initial begin
    test_reset();
    test_write_addr();
    test_back_to_back();
    test_read_seq();
    test_abort();
    test_timeout();
    test_reset_mid_tx();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
